// File: rtl/fir_pkg.sv
// Shared widths, FSM encoding and default coefficients for the time-multiplexed I/Q FIR.
package fir_pkg;

  localparam int N_TAPS  = 9;
  localparam int N_UNIQ  = (N_TAPS + 1) / 2;
  localparam int DATA_W  = 8;
  localparam int COEF_W  = 8;
  localparam int ACC_W   = 21;
  localparam int OUT_W   = 4;
  localparam int OUT_LSB = 11;
  localparam int PROD_W  = DATA_W + COEF_W;
  localparam int K_W     = 4;
  localparam int CA_W    = 3;

  typedef enum logic [1:0] {IDLE, MAC_I, MAC_Q, OUTPUT} fsm_t;

  // Element 0 is the centre tap; h = {-11,-23,26,75,105,75,26,-23,-11}.
  localparam logic [N_UNIQ-1:0][COEF_W-1:0] COEF_DEFAULT =
    {8'hF5, 8'hE9, 8'h1A, 8'h4B, 8'h69};

  // Symmetric filter: tap k shares coefficient |k - centre|.
  function automatic logic [CA_W-1:0] coef_idx(input logic [K_W-1:0] k);
    logic [K_W-1:0] centre;
    centre = K_W'(N_UNIQ - 1);
    return (k >= centre) ? CA_W'(k - centre) : CA_W'(centre - k);
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Shared signed multiplier feeding a single accumulator; exposes only the output bit slice
// of both the running accumulator and the sum that will be written at the next edge.
module fir_mac_unit
  import fir_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [COEF_W-1:0] b,
  output logic [OUT_W-1:0]         acc_slice,
  output logic [OUT_W-1:0]         sum_slice
);

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  sum;

  assign prod      = a * b;
  assign prod_ext  = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign sum       = acc + prod_ext;
  // Plain truncation of the slice: floor toward -inf, wraps on overflow.
  assign acc_slice = acc[OUT_LSB+OUT_W-1:OUT_LSB];
  assign sum_slice = sum[OUT_LSB+OUT_W-1:OUT_LSB];

  // Accumulator: clear wins over accumulate so a tap group can restart in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || clr) acc <= '0;
    else if (en)    acc <= sum;
  end

endmodule

// File: rtl/fir_tap_scheduler.sv
// Time-multiplexed 9-tap symmetric I/Q FIR: one MAC walks 9 I taps then 9 Q taps per sample.
// A sample accepted in cycle T produces a one-cycle ready pulse in cycle T+20.
module fir_tap_scheduler
  import fir_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sample_ready,
  input  logic [DATA_W-1:0] i_I_prefilter,
  input  logic [DATA_W-1:0] i_Q_prefilter,
  input  logic              i_coef_we,
  input  logic [CA_W-1:0]   i_coef_addr,
  input  logic [COEF_W-1:0] i_coef_data,
  output logic [OUT_W-1:0]  o_I_postfilter,
  output logic [OUT_W-1:0]  o_Q_postfilter,
  output logic              o_postfilter_ready,
  output logic              o_busy,
  output logic              o_overrun
);

  fsm_t                             state;
  logic [K_W-1:0]                   k;
  logic [N_TAPS-1:0][DATA_W-1:0]    x_i;
  logic [N_TAPS-1:0][DATA_W-1:0]    x_q;
  logic [N_UNIQ-1:0][COEF_W-1:0]    coef;
  logic [OUT_W-1:0]                 hold_i;

  logic              last;
  logic              mac_en;
  logic              mac_clr;
  logic [DATA_W-1:0] mac_a;
  logic [COEF_W-1:0] mac_b;
  logic [OUT_W-1:0]  acc_slice;
  logic [OUT_W-1:0]  sum_slice;

  assign last    = (k == K_W'(N_TAPS - 1));
  assign mac_en  = (state == MAC_I) || (state == MAC_Q);
  // Clear on sample accept, and between the I and Q passes.
  assign mac_clr = ((state == IDLE) && i_sample_ready) || ((state == MAC_I) && last);
  assign mac_a   = (state == MAC_Q) ? x_q[k] : x_i[k];
  assign mac_b   = coef[coef_idx(k)];

  fir_mac_unit u_mac (
    .clk       (i_clk),
    .rst       (i_rst),
    .clr       (mac_clr),
    .en        (mac_en),
    .a         (mac_a),
    .b         (mac_b),
    .acc_slice (acc_slice),
    .sum_slice (sum_slice)
  );

  // Coefficient bank: writes land only while idle and only to the 5 real registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      coef <= COEF_DEFAULT;
    end else if (i_coef_we && !o_busy) begin
      for (int j = 0; j < N_UNIQ; j++)
        if (i_coef_addr == CA_W'(j)) coef[j] <= i_coef_data;
    end
  end

  // Sequencer: sample intake, tap walk, output registers and status pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state              <= IDLE;
      k                  <= '0;
      x_i                <= '0;
      x_q                <= '0;
      hold_i             <= '0;
      o_I_postfilter     <= '0;
      o_Q_postfilter     <= '0;
      o_postfilter_ready <= 1'b0;
      o_busy             <= 1'b0;
      o_overrun          <= 1'b0;
    end else begin
      o_postfilter_ready <= 1'b0;
      // A sample arriving mid-computation is dropped and flagged; nothing else reacts.
      o_overrun          <= i_sample_ready && o_busy;
      case (state)
        IDLE: begin
          if (i_sample_ready) begin
            x_i    <= {x_i[N_TAPS-2:0], i_I_prefilter};
            x_q    <= {x_q[N_TAPS-2:0], i_Q_prefilter};
            k      <= '0;
            state  <= MAC_I;
            o_busy <= 1'b1;
          end
        end
        MAC_I: begin
          if (last) begin
            // Final I sum is only on the adder output this cycle; capture its slice now.
            hold_i <= sum_slice;
            k      <= '0;
            state  <= MAC_Q;
          end else begin
            k <= k + K_W'(1);
          end
        end
        MAC_Q: begin
          if (last) begin
            k     <= '0;
            state <= OUTPUT;
          end else begin
            k <= k + K_W'(1);
          end
        end
        OUTPUT: begin
          o_I_postfilter     <= hold_i;
          o_Q_postfilter     <= acc_slice;
          o_postfilter_ready <= 1'b1;
          o_busy             <= 1'b0;
          state              <= IDLE;
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tap_scheduler.sv
// Bench for fir_tap_scheduler: table vectors plus a convolution model feed a scoreboard
// that is checked on every ready pulse (values and 20-cycle latency).
module tb_fir_tap_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample;
  logic [7:0] in_i, in_q;
  logic       coef_we;
  logic [2:0] coef_addr;
  logic [7:0] coef_data;
  logic [3:0] out_i, out_q;
  logic       ready, busy, overrun;

  always #5 clk = ~clk;

  fir_tap_scheduler dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_sample_ready     (sample),
    .i_I_prefilter      (in_i),
    .i_Q_prefilter      (in_q),
    .i_coef_we          (coef_we),
    .i_coef_addr        (coef_addr),
    .i_coef_data        (coef_data),
    .o_I_postfilter     (out_i),
    .o_Q_postfilter     (out_q),
    .o_postfilter_ready (ready),
    .o_busy             (busy),
    .o_overrun          (overrun)
  );

  typedef struct { logic [3:0] ei; logic [3:0] eq; int t; } exp_t;
  typedef struct { int i; int q; logic [3:0] ei; logic [3:0] eq; } vec_t;

  exp_t sb[$];
  vec_t tab[10];
  int   total = 0, bad = 0, cyc = 0, ov_cnt = 0, ov_last = -1;
  int   mi[9], mq[9], mc[5];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---- reference model: direct symmetric convolution ----
  function automatic void model_reset();
    for (int k = 0; k < 9; k++) begin mi[k] = 0; mq[k] = 0; end
    mc[0] = 105; mc[1] = 75; mc[2] = 26; mc[3] = -23; mc[4] = -11;
  endfunction

  function automatic int dotp(input bit use_q);
    int s = 0;
    for (int k = 0; k < 9; k++)
      s += (use_q ? mq[k] : mi[k]) * mc[(k > 4) ? k - 4 : 4 - k];
    return s;
  endfunction

  function automatic logic [3:0] fold(input int s);
    logic [31:0] v;
    v = s;
    return v[14:11];
  endfunction

  function automatic void model_coef(input int a, input logic [7:0] d);
    logic signed [7:0] sd;
    sd = d;
    mc[a] = sd;
  endfunction

  // ---- monitor / scoreboard ----
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (ready) begin
        if (sb.size() == 0) check("unexpected_ready", 1, 0);
        else begin
          e = sb.pop_front();
          check("out_I", out_i, e.ei);
          check("out_Q", out_q, e.eq);
          check("latency", cyc - e.t, 20);
        end
      end
      if (overrun) begin ov_cnt++; ov_last = cyc; end
    end
  end

  // ---- stimulus helpers (entered just after a posedge) ----
  task automatic send(input int iv, input int qv, input bit use_tab,
                      input logic [3:0] ti, input logic [3:0] tq);
    exp_t e;
    in_i   = iv[7:0];
    in_q   = qv[7:0];
    sample = 1'b1;
    for (int k = 8; k > 0; k--) begin mi[k] = mi[k-1]; mq[k] = mq[k-1]; end
    mi[0] = iv; mq[0] = qv;
    e.ei = use_tab ? ti : fold(dotp(1'b0));
    e.eq = use_tab ? tq : fold(dotp(1'b1));
    e.t  = cyc;
    sb.push_back(e);
    @(posedge clk); #1;
    sample = 1'b0;
  endtask

  task automatic pulse_raw(input int iv, input int qv);
    in_i = iv[7:0]; in_q = qv[7:0]; sample = 1'b1;
    @(posedge clk); #1;
    sample = 1'b0;
  endtask

  task automatic gap19();
    repeat (19) @(posedge clk);
    #1;
  endtask

  task automatic run(input int iv, input int qv, input int n);
    for (int j = 0; j < n; j++) begin
      send(iv, qv, 1'b0, 4'h0, 4'h0);
      gap19();
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin @(posedge clk); n++; end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    sb.delete();
    @(posedge clk); #1;
  endtask

  task automatic wr(input int a, input logic [7:0] d, input bit accept);
    coef_we = 1'b1; coef_addr = a[2:0]; coef_data = d;
    if (accept) model_coef(a, d);
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int t0;
    rst = 1'b1; sample = 1'b0; in_i = '0; in_q = '0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_I", out_i, 0);
    check("rst_Q", out_q, 0);
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Impulse on I (127) and Q (-128): expected slices hand-derived from h*x >> 11 (floor).
    tab[0] = '{127, -128, 4'hF, 4'h0};
    tab[1] = '{0, 0, 4'hE, 4'h1};
    tab[2] = '{0, 0, 4'h1, 4'hE};
    tab[3] = '{0, 0, 4'h4, 4'hB};
    tab[4] = '{0, 0, 4'h6, 4'h9};
    tab[5] = '{0, 0, 4'h4, 4'hB};
    tab[6] = '{0, 0, 4'h1, 4'hE};
    tab[7] = '{0, 0, 4'hE, 4'h1};
    tab[8] = '{0, 0, 4'hF, 4'h0};
    tab[9] = '{0, 0, 4'h0, 4'h0};
    for (int j = 0; j < 10; j++) begin
      send(tab[j].i, tab[j].q, 1'b1, tab[j].ei, tab[j].eq);
      if (j == 0) check("busy_after_accept", busy, 1);
      gap19();  // next pulse lands in the same cycle as the previous ready
    end
    drain();
    check("rate_no_overrun", ov_cnt, 0);

    // Step on Q: steady state 127*239 = 30353 -> slice 14 (wraps, no saturation).
    run(0, 127, 10);
    drain();
    check("step_Q", out_q, 4'hE);
    check("step_I", out_i, 0);

    // Overrun: second pulse 5 cycles after the first is dropped.
    t0 = cyc;
    send(127, 0, 1'b0, 4'h0, 4'h0);
    repeat (4) @(posedge clk);
    #1;
    pulse_raw(-100, 55);
    @(negedge clk); #1;
    check("overrun_count", ov_cnt, 1);
    check("overrun_cycle", ov_last, t0 + 6);
    drain();
    check("overrun_width", ov_cnt, 1);
    check("idle_after_drain", busy, 0);
    run(3, -7, 2);  // delay lines must not contain the dropped sample
    drain();

    // Coefficients: centre to zero, then impulse -> 5th output 0.
    run(0, 0, 9);
    drain();
    wr(0, 8'h00, 1'b1);
    run(127, 0, 1);
    run(0, 0, 4);
    drain();
    check("coef0_zero_5th", out_i, 0);
    run(0, 0, 4);
    drain();
    // Write while busy is ignored.
    send(0, 0, 1'b0, 4'h0, 4'h0);
    wr(1, 8'h00, 1'b0);
    drain();
    // Out-of-range address is ignored.
    wr(5, 8'h7F, 1'b0);
    // Write in the same idle cycle as a sample: used by that computation.
    coef_we = 1'b1; coef_addr = 3'd2; coef_data = 8'h40;
    model_coef(2, 8'h40);
    send(100, -90, 1'b0, 4'h0, 4'h0);
    coef_we = 1'b0;
    gap19();
    for (int j = 0; j < 12; j++) begin
      send(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
           1'b0, 4'h0, 4'h0);
      gap19();
    end
    drain();

    // Reset during MAC_Q: no ready pulse, defaults restored.
    send(127, 127, 1'b0, 4'h0, 4'h0);
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    model_reset();
    check("midrst_I", out_i, 0);
    check("midrst_Q", out_q, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", ready, 0);
    repeat (15) @(posedge clk);
    #1;
    run(127, 0, 1);
    drain();
    check("post_rst_1st", out_i, 4'hF);
    run(0, 0, 4);
    drain();
    check("post_rst_5th", out_i, 4'h6);
    run(0, 0, 4);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
